// File: rtl/rob_queue_if.sv
// Handshake and data bundle between issue/CDB/register file and the reorder buffer.
interface rob_queue_if #(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ADDR_WIDTH     = 3,
  parameter int NUM_WB         = 2
);
  logic                         flush;
  logic                         alloc_valid;
  logic                         alloc_ready;
  logic                         alloc_reg_en;
  logic [REG_ADDR_WIDTH-1:0]    alloc_rd;
  logic [ADDR_WIDTH-1:0]        alloc_tag;
  logic [NUM_WB-1:0]            wb_valid;
  logic [NUM_WB*ADDR_WIDTH-1:0] wb_tag;
  logic [NUM_WB*XLEN-1:0]       wb_value;
  logic [ADDR_WIDTH-1:0]        snoop_tag;
  logic                         snoop_done;
  logic [XLEN-1:0]              snoop_value;
  logic                         commit_valid;
  logic                         commit_ready;
  logic                         commit_reg_en;
  logic [REG_ADDR_WIDTH-1:0]    commit_rd;
  logic [XLEN-1:0]              commit_value;
  logic [ADDR_WIDTH-1:0]        commit_tag;
  logic [ADDR_WIDTH:0]          count;
  logic                         empty;
  logic                         full;

  // Issue, CDB and register-file side
  modport master (
    output flush, alloc_valid, alloc_reg_en, alloc_rd, wb_valid, wb_tag, wb_value,
           snoop_tag, commit_ready,
    input  alloc_ready, alloc_tag, snoop_done, snoop_value, commit_valid,
           commit_reg_en, commit_rd, commit_value, commit_tag, count, empty, full
  );

  // Reorder buffer side
  modport slave (
    input  flush, alloc_valid, alloc_reg_en, alloc_rd, wb_valid, wb_tag, wb_value,
           snoop_tag, commit_ready,
    output alloc_ready, alloc_tag, snoop_done, snoop_value, commit_valid,
           commit_reg_en, commit_rd, commit_value, commit_tag, count, empty, full
  );
endinterface

// File: rtl/rob_queue.sv
// Reorder buffer: in-order allocate at the tail, out-of-order CDB writeback,
// combinational operand snoop with CDB forwarding, in-order commit at the head.
module rob_queue #(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ADDR_WIDTH     = 3,
  parameter int NUM_WB         = 2
) (
  input logic        clk,
  input logic        rst,
  rob_queue_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_DEPTH = DEPTH;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = 1;

  logic [DEPTH-1:0]          valid_q;
  logic [DEPTH-1:0]          done_q;
  logic [DEPTH-1:0]          reg_en_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q    [DEPTH];
  logic [XLEN-1:0]           value_q [DEPTH];

  logic [ADDR_WIDTH-1:0] head_q;
  logic [ADDR_WIDTH-1:0] tail_q;
  logic [ADDR_WIDTH:0]   count_q;

  logic [ADDR_WIDTH-1:0] wb_tag_a   [NUM_WB];
  logic [XLEN-1:0]       wb_value_a [NUM_WB];

  logic alloc_fire;
  logic commit_fire;
  logic snp_done;
  logic [XLEN-1:0] snp_value;

  // Unpack the CDB ports, port 0 in the LSBs
  for (genvar p = 0; p < NUM_WB; p++) begin : g_wb_unpack
    assign wb_tag_a[p]   = bus.wb_tag[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign wb_value_a[p] = bus.wb_value[p*XLEN +: XLEN];
  end

  // Ready depends only on occupancy, so a same-cycle commit never frees a slot for a full queue
  assign bus.alloc_ready = (count_q != CNT_DEPTH);
  assign bus.alloc_tag   = tail_q;
  assign bus.count       = count_q;
  assign bus.empty       = (count_q == '0);
  assign bus.full        = (count_q == CNT_DEPTH);

  assign bus.commit_valid  = valid_q[head_q] & done_q[head_q];
  assign bus.commit_reg_en = reg_en_q[head_q];
  assign bus.commit_rd     = rd_q[head_q];
  assign bus.commit_value  = value_q[head_q];
  assign bus.commit_tag    = head_q;

  assign alloc_fire  = bus.alloc_valid & bus.alloc_ready;
  assign commit_fire = bus.commit_valid & bus.commit_ready;

  // Snoop lookup with same-cycle CDB forwarding; later ports override earlier ones
  always_comb begin
    snp_done  = done_q[bus.snoop_tag];
    snp_value = value_q[bus.snoop_tag];
    for (int p = 0; p < NUM_WB; p++) begin
      if (bus.wb_valid[p] && (wb_tag_a[p] == bus.snoop_tag)) begin
        snp_done  = 1'b1;
        snp_value = wb_value_a[p];
      end
    end
  end

  assign bus.snoop_done  = valid_q[bus.snoop_tag] & snp_done;
  assign bus.snoop_value = snp_value;

  // Control state: entry valid/done bits, pointers and occupancy; flush mirrors reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (bus.flush) begin
      valid_q <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int p = 0; p < NUM_WB; p++) begin
        if (bus.wb_valid[p] && valid_q[wb_tag_a[p]]) begin
          done_q[wb_tag_a[p]] <= 1'b1;
        end
      end
      // Head and tail can only coincide when empty or full, where one of the two cannot fire
      if (commit_fire) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PTR_ONE;
      end
      if (alloc_fire) begin
        valid_q[tail_q] <= 1'b1;
        done_q[tail_q]  <= 1'b0;
        tail_q          <= tail_q + PTR_ONE;
      end
      case ({alloc_fire, commit_fire})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry payload: no reset needed, contents are only meaningful while the entry is valid
  always_ff @(posedge clk) begin
    if (!bus.flush) begin
      if (alloc_fire) begin
        reg_en_q[tail_q] <= bus.alloc_reg_en;
        rd_q[tail_q]     <= bus.alloc_rd;
      end
      for (int p = 0; p < NUM_WB; p++) begin
        if (bus.wb_valid[p] && valid_q[wb_tag_a[p]]) begin
          value_q[wb_tag_a[p]] <= wb_value_a[p];
        end
      end
    end
  end
endmodule

// File: tb/tb_rob_queue.sv
// Self-checking bench for rob_queue: scoreboard of allocated entries, checked at commit.
module tb_rob_queue;
  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int AW   = 3;
  localparam int NWB  = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rob_queue_if #(.XLEN(XLEN), .REG_ADDR_WIDTH(RW), .ADDR_WIDTH(AW), .NUM_WB(NWB)) bus ();

  rob_queue #(.XLEN(XLEN), .REG_ADDR_WIDTH(RW), .ADDR_WIDTH(AW), .NUM_WB(NWB)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [AW-1:0] tag;
    logic [RW-1:0] rd;
    logic          reg_en;
  } sb_t;

  sb_t           sb [$];
  logic [31:0]   exp_val [8];
  logic [AW-1:0] mt;
  int            n_chk  = 0;
  int            n_pass = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_alloc(input logic [RW-1:0] rd, input logic reg_en);
    bus.alloc_valid  = 1'b1;
    bus.alloc_rd     = rd;
    bus.alloc_reg_en = reg_en;
    #1;
    check("alloc_ready", bus.alloc_ready, 1);
    check("alloc_tag", bus.alloc_tag, mt);
    sb.push_back('{mt, rd, reg_en});
    mt++;
    step();
    bus.alloc_valid = 1'b0;
  endtask

  task automatic do_wb(input int port, input logic [AW-1:0] tag, input logic [31:0] val);
    bus.wb_valid = '0;
    bus.wb_valid[port] = 1'b1;
    bus.wb_tag[port*AW +: AW] = tag;
    bus.wb_value[port*XLEN +: XLEN] = val;
    exp_val[tag] = val;
    step();
    bus.wb_valid = '0;
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    sb.delete();
    mt = '0;
  endtask

  task automatic wait_empty(input int budget);
    for (int i = 0; i < budget && !bus.empty; i++) step();
    check("drain_empty", bus.empty, 1);
  endtask

  // Commit monitor: inputs are stable by the falling edge, so a handshake seen here fires next edge
  always @(negedge clk) begin
    sb_t e;
    if (!rst && !bus.flush && bus.commit_valid && bus.commit_ready) begin
      if (sb.size() == 0) begin
        check("commit_unexpected", 1, 0);
      end else begin
        e = sb.pop_front();
        check("commit_tag", bus.commit_tag, e.tag);
        check("commit_rd", bus.commit_rd, e.rd);
        check("commit_reg_en", bus.commit_reg_en, e.reg_en);
        check("commit_value", bus.commit_value, exp_val[e.tag]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst              = 1'b1;
    bus.flush        = 1'b0;
    bus.alloc_valid  = 1'b0;
    bus.alloc_reg_en = 1'b0;
    bus.alloc_rd     = '0;
    bus.wb_valid     = '0;
    bus.wb_tag       = '0;
    bus.wb_value     = '0;
    bus.snoop_tag    = '0;
    bus.commit_ready = 1'b0;
    mt               = '0;
    for (int i = 0; i < 8; i++) exp_val[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_alloc_ready", bus.alloc_ready, 1);
    check("rst_alloc_tag", bus.alloc_tag, 0);
    check("rst_commit_valid", bus.commit_valid, 0);
    check("rst_snoop_done", bus.snoop_done, 0);
    check("rst_count", bus.count, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_full", bus.full, 0);
    rst = 1'b0;
    step();

    // Fill all eight entries
    for (int i = 0; i < 8; i++) do_alloc(RW'(i + 8), 1'b1);
    check("fill_full", bus.full, 1);
    check("fill_ready", bus.alloc_ready, 0);
    check("fill_count", bus.count, 8);
    check("fill_empty", bus.empty, 0);

    // Full queue: allocate and commit in the same cycle -> only the commit fires
    do_wb(0, 3'd0, 32'h1000_0000);
    bus.commit_ready = 1'b1;
    bus.alloc_valid  = 1'b1;
    #1;
    check("full_commit_valid", bus.commit_valid, 1);
    check("full_alloc_ready", bus.alloc_ready, 0);
    step();
    bus.alloc_valid  = 1'b0;
    bus.commit_ready = 1'b0;
    check("full_commit_count", bus.count, 7);
    check("full_commit_tail", bus.alloc_tag, 0);
    check("full_commit_full", bus.full, 0);
    do_flush();

    // Out-of-order writeback, in-order commit
    do_alloc(5'd1, 1'b1);
    do_alloc(5'd2, 1'b0);
    do_alloc(5'd3, 1'b1);
    bus.commit_ready = 1'b1;
    do_wb(1, 3'd2, 32'h2222_2222);
    check("ooo_no_commit", bus.commit_valid, 0);
    do_wb(0, 3'd0, 32'h0000_00AA);
    do_wb(0, 3'd1, 32'h1111_1111);
    wait_empty(10);
    bus.commit_ready = 1'b0;
    check("ooo_count", bus.count, 0);

    // Dual-port write to one tag plus same-cycle snoop; head is tag 3 now
    do_alloc(5'd9, 1'b1);
    bus.wb_valid = 2'b11;
    bus.wb_tag   = {3'd3, 3'd3};
    bus.wb_value = {32'h0000_5555, 32'h0000_AAAA};
    exp_val[3]   = 32'h0000_5555;
    bus.snoop_tag = 3'd3;
    #1;
    check("snoop_fwd_done", bus.snoop_done, 1);
    check("snoop_fwd_value", bus.snoop_value, 32'h5555);
    step();
    bus.wb_valid = '0;
    check("snoop_stored_done", bus.snoop_done, 1);
    check("snoop_stored_value", bus.snoop_value, 32'h5555);
    bus.snoop_tag = 3'd4;
    #1;
    check("snoop_invalid", bus.snoop_done, 0);

    // Hold commit_ready low: the head stays presented and stable
    for (int i = 0; i < 3; i++) begin
      check("hold_valid", bus.commit_valid, 1);
      check("hold_tag", bus.commit_tag, 3);
      check("hold_rd", bus.commit_rd, 9);
      check("hold_value", bus.commit_value, 32'h5555);
      step();
    end
    // Asynchronous reset away from any clock edge
    #2;
    rst = 1'b1;
    #1;
    check("arst_commit_valid", bus.commit_valid, 0);
    check("arst_count", bus.count, 0);
    check("arst_empty", bus.empty, 1);
    check("arst_alloc_tag", bus.alloc_tag, 0);
    rst = 1'b0;
    sb.delete();
    mt = '0;
    step();

    // Writeback to an entry that is not valid is dropped
    do_alloc(5'd4, 1'b1);
    do_wb(0, 3'd1, 32'hDEAD_BEEF);
    do_alloc(5'd5, 1'b1);
    bus.snoop_tag = 3'd1;
    #1;
    check("wb_invalid_ignored", bus.snoop_done, 0);
    check("wb_invalid_head", bus.commit_valid, 0);
    do_flush();

    // Wrap the pointers, then flush against a writeback and a commit
    for (int i = 0; i < 5; i++) do_alloc(RW'(i), 1'b1);
    bus.commit_ready = 1'b1;
    for (int i = 0; i < 5; i++) do_wb(i % 2, AW'(i), 32'h100 + i);
    wait_empty(10);
    bus.commit_ready = 1'b0;
    for (int i = 0; i < 5; i++) do_alloc(RW'(10 + i), i[0]);
    check("wrap_count", bus.count, 5);
    check("wrap_tail", bus.alloc_tag, 2);
    do_wb(1, 3'd5, 32'h0000_0555);
    check("wrap_head_ready", bus.commit_valid, 1);
    bus.flush        = 1'b1;
    bus.commit_ready = 1'b1;
    bus.wb_valid     = 2'b01;
    bus.wb_tag       = {3'd0, 3'd6};
    bus.wb_value     = {32'h0, 32'h0000_0666};
    step();
    bus.flush    = 1'b0;
    bus.wb_valid = '0;
    sb.delete();
    mt = '0;
    check("flush_count", bus.count, 0);
    check("flush_empty", bus.empty, 1);
    check("flush_alloc_tag", bus.alloc_tag, 0);
    check("flush_commit_valid", bus.commit_valid, 0);
    bus.snoop_tag = 3'd6;
    #1;
    check("flush_snoop", bus.snoop_done, 0);
    step();
    check("post_flush_count", bus.count, 0);
    bus.commit_ready = 1'b0;

    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
